// File: rtl/ball_engine_if.sv
// Pixel-plot bus between the ball engine and its host: paddle/enable inputs,
// VGA pixel strobe and score pulses.
interface ball_engine_if;
  logic       enable;
  logic [8:0] p1_y;
  logic [8:0] p2_y;
  logic [9:0] x;
  logic [8:0] y;
  logic [2:0] colour;
  logic       plot;
  logic       score_p1;
  logic       score_p2;

  modport master (
    output enable, p1_y, p2_y,
    input  x, y, colour, plot, score_p1, score_p2
  );

  modport slave (
    input  enable, p1_y, p2_y,
    output x, y, colour, plot, score_p1, score_p2
  );
endinterface

// File: rtl/ball_engine.sv
// Pong ball engine: once per frame tick, erases the ball, moves it one pixel
// (walls, paddles, misses) and redraws it through a registered pixel strobe.
module ball_engine #(
  parameter int unsigned BALL_SIZE   = 4,
  parameter int unsigned SCREEN_W    = 320,
  parameter int unsigned SCREEN_H    = 240,
  parameter int unsigned PADDLE_H    = 32,
  parameter int unsigned P1_FACE     = 10,
  parameter int unsigned P2_FACE     = 310,
  parameter int unsigned FRAME_TICKS = 833333
) (
  input  logic          clk,
  input  logic          rst,
  ball_engine_if.slave  bus
);

  localparam int unsigned TW = $clog2(FRAME_TICKS);
  localparam int unsigned PW = (BALL_SIZE > 1) ? $clog2(BALL_SIZE) : 1;

  localparam logic [9:0]    X_MAX    = 10'(SCREEN_W - BALL_SIZE);
  localparam logic [8:0]    Y_MAX    = 9'(SCREEN_H - BALL_SIZE);
  localparam logic [9:0]    X_CTR    = 10'((SCREEN_W - BALL_SIZE) / 2);
  localparam logic [8:0]    Y_CTR    = 9'((SCREEN_H - BALL_SIZE) / 2);
  localparam logic [9:0]    X_P1     = 10'(P1_FACE);
  localparam logic [9:0]    X_P2     = 10'(P2_FACE - BALL_SIZE);
  localparam logic [9:0]    BS_M1    = 10'(BALL_SIZE - 1);
  localparam logic [9:0]    PH_M1    = 10'(PADDLE_H - 1);
  localparam logic [PW-1:0] PIX_LAST = PW'(BALL_SIZE - 1);

  typedef enum logic [1:0] {IDLE, ERASE, MOVE, DRAW} state_e;

  state_e        state_q, state_d;
  logic [TW-1:0] tick_q, tick_d;
  logic          tick;
  logic [PW-1:0] px_q, px_d, py_q, py_d;
  logic          pix_last;
  logic [9:0]    ball_x_q, ball_x_d;
  logic [8:0]    ball_y_q, ball_y_d;
  logic          dir_x_q, dir_x_d;   // 1 = right
  logic          dir_y_q, dir_y_d;   // 1 = down
  logic          dir_x_nx, dir_y_nx;
  logic          miss_l, miss_r, ov1, ov2;
  logic [9:0]    x_q, x_d;
  logic [8:0]    y_q, y_d;
  logic [2:0]    colour_q, colour_d;
  logic          plot_q, plot_d;
  logic          score_p1_q, score_p1_d;
  logic          score_p2_q, score_p2_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      tick_q     <= '0;
      px_q       <= '0;
      py_q       <= '0;
      ball_x_q   <= X_CTR;
      ball_y_q   <= Y_CTR;
      dir_x_q    <= 1'b1;
      dir_y_q    <= 1'b1;
      x_q        <= '0;
      y_q        <= '0;
      colour_q   <= '0;
      plot_q     <= 1'b0;
      score_p1_q <= 1'b0;
      score_p2_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      tick_q     <= tick_d;
      px_q       <= px_d;
      py_q       <= py_d;
      ball_x_q   <= ball_x_d;
      ball_y_q   <= ball_y_d;
      dir_x_q    <= dir_x_d;
      dir_y_q    <= dir_y_d;
      x_q        <= x_d;
      y_q        <= y_d;
      colour_q   <= colour_d;
      plot_q     <= plot_d;
      score_p1_q <= score_p1_d;
      score_p2_q <= score_p2_d;
    end
  end

  assign tick     = (tick_q == TW'(FRAME_TICKS - 1));
  assign tick_d   = tick ? '0 : tick_q + TW'(1);
  assign pix_last = (px_q == PIX_LAST) && (py_q == PIX_LAST);

  always_comb begin
    state_d = state_q;
    px_d    = '0;
    py_d    = '0;
    case (state_q)
      IDLE:  if (tick && bus.enable) state_d = ERASE;
      ERASE, DRAW: begin
        if (pix_last) begin
          state_d = (state_q == ERASE) ? MOVE : IDLE;
        end else if (px_q == PIX_LAST) begin
          py_d = py_q + PW'(1);
        end else begin
          px_d = px_q + PW'(1);
          py_d = py_q;
        end
      end
      MOVE:    state_d = DRAW;
      default: state_d = IDLE;
    endcase
  end

  assign miss_l = !dir_x_q && (ball_x_q == '0);
  assign miss_r = dir_x_q && (ball_x_q == X_MAX);
  assign ov1 = ({1'b0, ball_y_q} + BS_M1 >= {1'b0, bus.p1_y}) &&
               ({1'b0, ball_y_q} <= {1'b0, bus.p1_y} + PH_M1);
  assign ov2 = ({1'b0, ball_y_q} + BS_M1 >= {1'b0, bus.p2_y}) &&
               ({1'b0, ball_y_q} <= {1'b0, bus.p2_y} + PH_M1);

  always_comb begin
    dir_y_nx = dir_y_q;
    if (!dir_y_q && (ball_y_q == '0))        dir_y_nx = 1'b1;
    else if (dir_y_q && (ball_y_q == Y_MAX)) dir_y_nx = 1'b0;
    dir_x_nx = dir_x_q;
    if (!dir_x_q && (ball_x_q == X_P1) && ov1)      dir_x_nx = 1'b1;
    else if (dir_x_q && (ball_x_q == X_P2) && ov2)  dir_x_nx = 1'b0;

    ball_x_d = ball_x_q;
    ball_y_d = ball_y_q;
    dir_x_d  = dir_x_q;
    dir_y_d  = dir_y_q;
    if (state_q == MOVE) begin
      if (miss_l || miss_r) begin
        ball_x_d = X_CTR;
        ball_y_d = Y_CTR;
        dir_x_d  = miss_l;
      end else begin
        dir_x_d  = dir_x_nx;
        dir_y_d  = dir_y_nx;
        ball_x_d = dir_x_nx ? ball_x_q + 10'd1 : ball_x_q - 10'd1;
        ball_y_d = dir_y_nx ? ball_y_q + 9'd1  : ball_y_q - 9'd1;
      end
    end
  end

  // Output registers load from next-state values so the first pixel (and the
  // score pulse of the MOVE cycle) appear one cycle after the deciding edge.
  always_comb begin
    x_d        = x_q;
    y_d        = y_q;
    colour_d   = colour_q;
    plot_d     = 1'b0;
    score_p1_d = (state_d == MOVE) && miss_r;
    score_p2_d = (state_d == MOVE) && miss_l;
    if ((state_d == ERASE) || (state_d == DRAW)) begin
      plot_d   = 1'b1;
      x_d      = ball_x_d + 10'(px_d);
      y_d      = ball_y_d + 9'(py_d);
      colour_d = (state_d == DRAW) ? 3'b111 : 3'b000;
    end
  end

  assign bus.x        = x_q;
  assign bus.y        = y_q;
  assign bus.colour   = colour_q;
  assign bus.plot     = plot_q;
  assign bus.score_p1 = score_p1_q;
  assign bus.score_p2 = score_p2_q;

endmodule

// File: tb/tb_ball_engine.sv
// Self-checking bench for ball_engine with FRAME_TICKS=64, other parameters default.
module tb_ball_engine;
  localparam int FT = 64;

  int   checks   = 0;
  int   failures = 0;
  logic clk = 1'b0;
  logic rst;

  ball_engine_if bus();

  ball_engine #(.FRAME_TICKS(FT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic void chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endfunction

  // Reference model: position and +/-1 velocity per axis, one call per move.
  int mbx, mby, mvx, mvy;

  task automatic model_move(input int p1, input int p2, output bit s1, output bit s2);
    bit h1, h2;
    s1 = 1'b0;
    s2 = 1'b0;
    if (mvx < 0 && mbx == 0) begin
      s2 = 1'b1; mbx = 158; mby = 118; mvx = 1;
    end else if (mvx > 0 && mbx == 316) begin
      s1 = 1'b1; mbx = 158; mby = 118; mvx = -1;
    end else begin
      if (mvy < 0 && mby == 0)        mvy = 1;
      else if (mvy > 0 && mby == 236) mvy = -1;
      h1 = (mby + 3 >= p1) && (mby <= p1 + 31);
      h2 = (mby + 3 >= p2) && (mby <= p2 + 31);
      if (mvx < 0 && mbx == 10 && h1)       mvx = 1;
      else if (mvx > 0 && mbx == 306 && h2) mvx = -1;
      mbx += mvx;
      mby += mvy;
    end
  endtask

  logic [9:0] f_bx;
  logic [8:0] f_by;
  logic       f_rx, f_dn;

  task automatic force_ball(input int bx, input int by, input bit rx, input bit dn);
    f_bx = 10'(bx);
    f_by = 9'(by);
    f_rx = rx;
    f_dn = dn;
    force dut.ball_x_q = f_bx;
    force dut.ball_y_q = f_by;
    force dut.dir_x_q  = f_rx;
    force dut.dir_y_q  = f_dn;
    @(posedge clk);
    #1;
    release dut.ball_x_q;
    release dut.ball_y_q;
    release dut.dir_x_q;
    release dut.dir_y_q;
    @(negedge clk);
  endtask

  task automatic wait_plot(input int limit, output int n);
    n = 0;
    while (bus.plot !== 1'b1 && n < limit) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic pix_phase(input string nm, input bit first_now, input int bx, input int by,
                           input int col);
    int bad = 0;
    int wx, wy;
    for (int k = 0; k < 16; k++) begin
      if (k > 0 || !first_now) @(negedge clk);
      wx = bx + k % 4;
      wy = by + k / 4;
      if (bus.plot !== 1'b1 || bus.x !== 10'(wx) || bus.y !== 9'(wy) ||
          bus.colour !== 3'(col) || bus.score_p1 !== 1'b0 || bus.score_p2 !== 1'b0) begin
        if (bad == 0)
          $display("FAIL %s pixel %0d: got x=%0d y=%0d c=%0d plot=%0b s=%0b%0b want x=%0d y=%0d c=%0d plot=1 s=00",
                   nm, k, bus.x, bus.y, bus.colour, bus.plot, bus.score_p1, bus.score_p2,
                   wx, wy, col);
        bad++;
      end
    end
    checks++;
    if (bad != 0) failures++;
  endtask

  task automatic seq_check(input string nm, input int ex, input int ey, input int dx,
                           input int dy, input bit s1, input bit s2);
    int n;
    wait_plot(200, n);
    if (bus.plot !== 1'b1) begin
      chk({nm, " start timeout"}, 0, 1);
      return;
    end
    pix_phase({nm, " erase"}, 1'b1, ex, ey, 0);
    @(negedge clk);
    chk({nm, " move plot"}, int'(bus.plot), 0);
    chk({nm, " move score_p1"}, int'(bus.score_p1), int'(s1));
    chk({nm, " move score_p2"}, int'(bus.score_p2), int'(s2));
    chk({nm, " move hold x"}, int'(bus.x), ex + 3);
    pix_phase({nm, " draw"}, 1'b0, dx, dy, 7);
    @(negedge clk);
    chk({nm, " end plot"}, int'(bus.plot), 0);
    chk({nm, " end hold y"}, int'(bus.y), dy + 3);
  endtask

  function automatic int aim(input int by);
    int p = by + 3 - int'($urandom_range(0, 36));
    return (p < 0) ? 0 : p;
  endfunction

  typedef struct {
    bit frc;
    int bx, by;
    bit rx, dn;
    int p1, p2;
    int ex, ey, dx, dy;
    bit s1, s2;
  } vec_t;

  vec_t vt[$];

  initial begin
    int n, p1, p2, ex, ey, pc;
    bit s1, s2;

    //           frc  bx   by  rx dn  p1   p2   ex   ey   dx   dy  s1 s2
    vt.push_back('{1, 100, 236, 1, 1,   0,   0, 100, 236, 101, 235, 0, 0});
    vt.push_back('{0,   0,   0, 0, 0,   0,   0, 101, 235, 102, 234, 0, 0});
    vt.push_back('{1, 100,   0, 0, 0,   0,   0, 100,   0,  99,   1, 0, 0});
    vt.push_back('{0,   0,   0, 0, 0,   0,   0,  99,   1,  98,   2, 0, 0});
    vt.push_back('{1,  10,  50, 0, 1,  40,   0,  10,  50,  11,  51, 0, 0});
    vt.push_back('{0,   0,   0, 0, 0,  40,   0,  11,  51,  12,  52, 0, 0});
    vt.push_back('{1,  10,  50, 0, 1,  53,   0,  10,  50,  11,  51, 0, 0});
    vt.push_back('{1,  10,  50, 0, 1,  54,   0,  10,  50,   9,  51, 0, 0});
    vt.push_back('{1,  10,  50, 0, 1,  19,   0,  10,  50,  11,  51, 0, 0});
    vt.push_back('{1,  10,  50, 0, 1,  18,   0,  10,  50,   9,  51, 0, 0});
    vt.push_back('{1, 306, 100, 1, 1,   0,  90, 306, 100, 305, 101, 0, 0});
    vt.push_back('{1, 306, 100, 1, 1,   0, 200, 306, 100, 307, 101, 0, 0});
    vt.push_back('{1,   0,  50, 0, 1,   0,   0,   0,  50, 158, 118, 0, 1});
    vt.push_back('{0,   0,   0, 0, 0,   0,   0, 158, 118, 159, 119, 0, 0});
    vt.push_back('{1, 316,   0, 1, 0,   0,   0, 316,   0, 158, 118, 1, 0});
    vt.push_back('{0,   0,   0, 0, 0,   0,   0, 158, 118, 157, 117, 0, 0});
    vt.push_back('{1, 306, 236, 1, 1,   0, 230, 306, 236, 305, 235, 0, 0});
    vt.push_back('{1,  10,   0, 0, 0,   0,   0,  10,   0,  11,   1, 0, 0});

    rst        = 1'b1;
    bus.enable = 1'b1;
    bus.p1_y   = '0;
    bus.p2_y   = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset plot", int'(bus.plot), 0);
    chk("reset x", int'(bus.x), 0);
    chk("reset y", int'(bus.y), 0);
    chk("reset colour", int'(bus.colour), 0);
    chk("reset score_p1", int'(bus.score_p1), 0);
    chk("reset score_p2", int'(bus.score_p2), 0);
    rst = 1'b0;

    wait_plot(200, n);
    chk("first tick latency", n, FT);
    seq_check("first", 158, 118, 159, 119, 1'b0, 1'b0);
    wait_plot(200, n);
    chk("idle gap to next tick", n, FT - 33);
    seq_check("second", 159, 119, 160, 120, 1'b0, 1'b0);

    foreach (vt[i]) begin
      bus.p1_y = 9'(vt[i].p1);
      bus.p2_y = 9'(vt[i].p2);
      if (vt[i].frc) force_ball(vt[i].bx, vt[i].by, vt[i].rx, vt[i].dn);
      seq_check($sformatf("vec%0d", i), vt[i].ex, vt[i].ey, vt[i].dx, vt[i].dy,
                vt[i].s1, vt[i].s2);
    end

    // Paddle out of reach: ball walks from x=10 to the left edge and scores.
    bus.p1_y = 9'd200;
    bus.p2_y = 9'd0;
    force_ball(10, 50, 1'b0, 1'b1);
    for (int i = 0; i < 10; i++)
      seq_check($sformatf("walk%0d", i), 10 - i, 50 + i, 9 - i, 51 + i, 1'b0, 1'b0);
    seq_check("walk_miss", 0, 60, 158, 118, 1'b0, 1'b1);

    force_ball(158, 118, 1'b1, 1'b1);
    mbx = 158; mby = 118; mvx = 1; mvy = 1;
    p1 = 0; p2 = 0;
    for (int i = 0; i < 300; i++) begin
      p1 = ($urandom_range(0, 9) < 7) ? aim(mby) : int'($urandom_range(0, 208));
      p2 = ($urandom_range(0, 9) < 7) ? aim(mby) : int'($urandom_range(0, 208));
      bus.p1_y = 9'(p1);
      bus.p2_y = 9'(p2);
      ex = mbx;
      ey = mby;
      model_move(p1, p2, s1, s2);
      seq_check($sformatf("rnd%0d", i), ex, ey, mbx, mby, s1, s2);
    end

    // enable dropped during ERASE: sequence finishes, then nothing more.
    wait_plot(200, n);
    bus.enable = 1'b0;
    ex = mbx;
    ey = mby;
    model_move(p1, p2, s1, s2);
    seq_check("en_drop", ex, ey, mbx, mby, s1, s2);
    pc = 0;
    repeat (3 * FT + 20) begin
      @(negedge clk);
      if (bus.plot === 1'b1) pc++;
    end
    chk("enable low plots", pc, 0);

    bus.enable = 1'b1;
    wait_plot(200, n);
    repeat (4) @(negedge clk);
    chk("fifth erase pixel plot", int'(bus.plot), 1);
    rst = 1'b1;
    @(negedge clk);
    chk("abort plot", int'(bus.plot), 0);
    chk("abort x", int'(bus.x), 0);
    chk("abort y", int'(bus.y), 0);
    chk("abort colour", int'(bus.colour), 0);
    rst = 1'b0;
    wait_plot(200, n);
    chk("latency after abort", n, FT);
    seq_check("post_abort", 158, 118, 159, 119, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
